parameters: RTL and testbench
=============================

# nios_fprint_processor2_0_cpu1_jtag_debug_host_driver

Synthesizable virtual-JTAG initiator for the processor debug module. It accepts a debug command (2-bit instruction plus data word) on a valid/ready handshake and drives the virtual-JTAG strobes, TCK and TDI seen by the debug module's TCK-side shift register. It captures TDO into a response word. It lets on-chip logic or a self-checking bench exercise the debug slave without a physical JTAG hub.

## Interface
Parameters:
- SR_WIDTH, 38, scan-chain length in bits.
- IR_WIDTH, 2, virtual instruction width.
- TCK_DIV, 2, clk cycles per TCK half-period (≥1).

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_ir  in  IR_WIDTH  instruction for this command.
- cmd_data  in  SR_WIDTH  word shifted out on TDI, LSB first.
- rsp_valid  out  1  one-cycle pulse; rsp_data valid.
- rsp_data  out  SR_WIDTH  captured TDO bits, first bit at [0]; held until next capture.
- busy  out  1  high from acceptance until rsp_valid inclusive.
- vji_tck, vji_tdi  out  1  generated TCK and TDI.
- vji_tdo  in  1  TDO from debug module.
- vji_ir_in  out  IR_WIDTH  instruction register, updated in UIR, held afterwards.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1  virtual state strobes.

## Operation
- States: IDLE → UIR → CDR → SHIFT → UDR → [RTI] → DONE → IDLE.
- Acceptance: clk edge with cmd_valid && cmd_ready. That edge latches cmd_ir/cmd_data, enters UIR and sets busy.
- Phase unit = one TCK period = 2*TCK_DIV clk. Within a period, vji_tck is low for TCK_DIV cycles, then high for TCK_DIV cycles.
- UIR: 1 period. vji_uir=1; vji_ir_in loads cmd_ir on entry.
- CDR: 1 period. vji_cdr=1.
- SHIFT: SR_WIDTH periods. vji_sdr=1.
  - vji_tdi = bit k of the latched data during period k, updated at the period start.
  - vji_tdo is sampled on the clk edge that drives vji_tck high.
  - Capture register shifts right with the sample entering the MSB, so after SR_WIDTH samples the first sample sits at [0].
- UDR: 1 period. vji_udr=1.
- DONE: 1 clk. rsp_data is updated, rsp_valid=1; next state IDLE.
- Exactly one strobe is high at a time; all strobes are 0 in IDLE and DONE.
- vji_tck toggles only in UIR/CDR/SHIFT/UDR/RTI and is low otherwise.
- cmd_valid outside IDLE is ignored; no queuing. A command presented in the DONE cycle is accepted on the following IDLE cycle.
- Phase counter: ceil(log2(2*TCK_DIV)) bits. Bit counter: ceil(log2(SR_WIDTH+1)) bits, wraps to 0 on leaving SHIFT.

## Timing
- Reset values: cmd_ready=1 (IDLE); rsp_valid, busy, vji_tck, vji_tdi, all strobes = 0; vji_ir_in=0; rsp_data=0.
- Reset asserted mid-command: immediate return to IDLE with the above values. No rsp_valid; the partial capture is discarded.
- Latency from the acceptance edge to the rsp_valid cycle:
  - 2*TCK_DIV*(SR_WIDTH+3)+1 clk (165 with defaults).
  - Plus 8*TCK_DIV clk when RTI is compiled in (181).
- cmd_ready deasserts the cycle after acceptance and reasserts the cycle after rsp_valid.

## Configuration
- JTAG_HOST_RTI_EN defined:
  - After UDR, the RTI state holds vji_rti=1 for 4 TCK periods with TCK toggling.
  - This lets the debug module raise st_ready_test_idle before DONE.
- Undefined:
  - UDR goes directly to DONE.
  - vji_rti is tied 0.

## Test plan
- Loopback (vji_tdo=vji_tdi), cmd_ir=2'b01, cmd_data=38'h25_A5A5_C3C3 → rsp_data=38'h25_A5A5_C3C3; rsp_valid exactly 165 clk after acceptance (181 with JTAG_HOST_RTI_EN); vji_ir_in=2'b01 from UIR onward.
- vji_tdo tied 1, cmd_data=0 → rsp_data=38'h3F_FFFF_FFFF; vji_tdi low for all 38 SHIFT periods.
- Strobe ordering: count TCK rising edges per strobe → uir 1, cdr 1, sdr 38, udr 1, rti 4/0; never two strobes high at once.
- Back-to-back: cmd_valid held high with two commands → second accepted the cycle after rsp_valid; cmd_valid pulses during busy are ignored (exactly 2 responses).
- Reset asserted at SHIFT bit 20 → all outputs at reset values within the same cycle; no rsp_valid; the next command completes normally.
- TCK_DIV=1 → vji_tck period 2 clk; loopback of 38'h00_0000_0001 returns the same; latency 83 clk (91 with RTI).

Source files
------------

// File: rtl/parameters_if.sv
// Debug-command handshake and virtual-JTAG pin bundle between a command initiator and the host driver.
interface parameters_if #(
  parameter int SR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [SR_WIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic [SR_WIDTH-1:0] rsp_data;
  logic                busy;
  logic                vji_tck;
  logic                vji_tdi;
  logic                vji_tdo;
  logic [IR_WIDTH-1:0] vji_ir_in;
  logic                vji_uir;
  logic                vji_cdr;
  logic                vji_sdr;
  logic                vji_udr;
  logic                vji_rti;

  modport master (
    output cmd_valid, cmd_ir, cmd_data, vji_tdo,
    input  cmd_ready, rsp_valid, rsp_data, busy, vji_tck, vji_tdi, vji_ir_in,
           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_data, vji_tdo,
    output cmd_ready, rsp_valid, rsp_data, busy, vji_tck, vji_tdi, vji_ir_in,
           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
  );
endinterface

// File: rtl/parameters.sv
// Virtual-JTAG debug host: one command -> UIR/CDR/SHIFT/UDR[/RTI with JTAG_HOST_RTI_EN] -> response; 2*TCK_DIV*(SR_WIDTH+3)+1 clk.
// Single command in flight: cmd_ready only in IDLE, cmd_valid elsewhere ignored; response is a one-cycle pulse with no stall.
module parameters #(
  parameter int SR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic      clk,
  input  logic      reset_n,
  parameters_if.slave bus
);
  localparam int PW = (2 * TCK_DIV > 1) ? $clog2(2 * TCK_DIV) : 1;
  localparam int BW = $clog2(SR_WIDTH + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(2 * TCK_DIV - 1);
  localparam logic [PW-1:0] PH_HI    = PW'(TCK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SR_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, UIR, CDR, SHIFT, UDR, RTI, DONE} state_t;

  state_t              state;
  logic [PW-1:0]       phase;
  logic [BW-1:0]       bit_cnt;
  logic [SR_WIDTH-1:0] data_q;
  logic [SR_WIDTH-1:0] cap;
`ifdef JTAG_HOST_RTI_EN
  logic                rti_q;
  assign bus.vji_rti = rti_q;
`else
  assign bus.vji_rti = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      phase         <= '0;
      bit_cnt       <= '0;
      data_q        <= '0;
      cap           <= '0;
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.busy      <= 1'b0;
      bus.vji_tck   <= 1'b0;
      bus.vji_tdi   <= 1'b0;
      bus.vji_ir_in <= '0;
      bus.vji_uir   <= 1'b0;
      bus.vji_cdr   <= 1'b0;
      bus.vji_sdr   <= 1'b0;
      bus.vji_udr   <= 1'b0;
`ifdef JTAG_HOST_RTI_EN
      rti_q         <= 1'b0;
`endif
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            state         <= UIR;
            data_q        <= bus.cmd_data;
            bus.vji_ir_in <= bus.cmd_ir;
            bus.vji_uir   <= 1'b1;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
            phase         <= '0;
            bus.vji_tck   <= 1'b0;
          end
        end
        DONE: begin
          state         <= IDLE;
          bus.cmd_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end
        default: begin
          if (phase == PH_LAST) begin
            // Period boundary: TCK returns low and the next state's strobe takes over.
            phase       <= '0;
            bus.vji_tck <= 1'b0;
            case (state)
              UIR: begin
                state       <= CDR;
                bus.vji_uir <= 1'b0;
                bus.vji_cdr <= 1'b1;
              end
              CDR: begin
                state       <= SHIFT;
                bus.vji_cdr <= 1'b0;
                bus.vji_sdr <= 1'b1;
                bus.vji_tdi <= data_q[0];
                data_q      <= data_q >> 1;
              end
              SHIFT: begin
                if (bit_cnt == BIT_LAST) begin
                  state       <= UDR;
                  bit_cnt     <= '0;
                  bus.vji_sdr <= 1'b0;
                  bus.vji_udr <= 1'b1;
                  bus.vji_tdi <= 1'b0;
                end else begin
                  bit_cnt     <= bit_cnt + BW'(1);
                  bus.vji_tdi <= data_q[0];
                  data_q      <= data_q >> 1;
                end
              end
              UDR: begin
                bus.vji_udr <= 1'b0;
`ifdef JTAG_HOST_RTI_EN
                state       <= RTI;
                rti_q       <= 1'b1;
`else
                state         <= DONE;
                bus.rsp_valid <= 1'b1;
                bus.rsp_data  <= cap;
`endif
              end
`ifdef JTAG_HOST_RTI_EN
              RTI: begin
                if (bit_cnt == BW'(3)) begin
                  state         <= DONE;
                  bit_cnt       <= '0;
                  rti_q         <= 1'b0;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_data  <= cap;
                end else begin
                  bit_cnt <= bit_cnt + BW'(1);
                end
              end
`endif
              default: state <= IDLE;
            endcase
          end else begin
            phase <= phase + PW'(1);
            if (phase == PH_HI) begin
              bus.vji_tck <= 1'b1;
              if (state == SHIFT) cap <= {bus.vji_tdo, cap[SR_WIDTH-1:1]};
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_parameters.sv
// Directed bench for the virtual-JTAG host: expected responses queued at drive time, compared when rsp_valid appears.
module tb_parameters;
  localparam int SR = 38;
  localparam int IR = 2;
`ifdef JTAG_HOST_RTI_EN
  localparam int RTI_N = 4;
`else
  localparam int RTI_N = 0;
`endif
  localparam int LAT2 = 2 * 2 * (SR + 3 + RTI_N) + 1;
  localparam int LAT1 = 2 * 1 * (SR + 3 + RTI_N) + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic loop_mode = 1'b1;
  logic tdo_force = 1'b0;
  always #5 clk = ~clk;

  parameters_if #(.SR_WIDTH(SR), .IR_WIDTH(IR)) b0 ();
  parameters_if #(.SR_WIDTH(SR), .IR_WIDTH(IR)) b1 ();

  parameters #(.SR_WIDTH(SR), .IR_WIDTH(IR), .TCK_DIV(2)) u_dut0 (.clk(clk), .reset_n(reset_n), .bus(b0));
  parameters #(.SR_WIDTH(SR), .IR_WIDTH(IR), .TCK_DIV(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(b1));

  assign b0.vji_tdo = loop_mode ? b0.vji_tdi : tdo_force;
  assign b1.vji_tdo = b1.vji_tdi;

  int n_tests = 0;
  int n_fail  = 0;
  logic [SR-1:0] exp_q[$];

  // Observation side: everything here is append-only so the directed sequence only reads it.
  int cyc = 0;
  int acc_hist[$];
  int rsp_cyc_hist[$];
  logic [SR-1:0] rsp_dat_hist[$];
  int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_rti = 0, n_tdi_hi = 0;
  logic prev_tck = 1'b0;
  logic multi_strobe = 1'b0;
  logic tck_stray = 1'b0;
  logic [IR-1:0] uir_ir = '0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset_n && b0.cmd_valid && b0.cmd_ready) acc_hist.push_back(cyc);
  end

  always @(negedge clk) begin
    if (b0.vji_tck && !prev_tck) begin
      if (b0.vji_uir) begin n_uir = n_uir + 1; uir_ir = b0.vji_ir_in; end
      if (b0.vji_cdr) n_cdr = n_cdr + 1;
      if (b0.vji_sdr) n_sdr = n_sdr + 1;
      if (b0.vji_udr) n_udr = n_udr + 1;
      if (b0.vji_rti) n_rti = n_rti + 1;
      if (b0.vji_sdr && b0.vji_tdi) n_tdi_hi = n_tdi_hi + 1;
    end
    prev_tck = b0.vji_tck;
    if (int'(b0.vji_uir) + int'(b0.vji_cdr) + int'(b0.vji_sdr) + int'(b0.vji_udr) + int'(b0.vji_rti) > 1)
      multi_strobe = 1'b1;
    if (b0.vji_tck && !(b0.vji_uir || b0.vji_cdr || b0.vji_sdr || b0.vji_udr || b0.vji_rti))
      tck_stray = 1'b1;
    if (b0.rsp_valid) begin
      rsp_cyc_hist.push_back(cyc);
      rsp_dat_hist.push_back(b0.rsp_data);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int acc_idx = 0;
  int rsp_idx = 0;

  task automatic send(input logic [IR-1:0] ir, input logic [SR-1:0] d);
    @(negedge clk);
    b0.cmd_valid = 1'b1;
    b0.cmd_ir    = ir;
    b0.cmd_data  = d;
    for (int i = 0; i < 400 && !b0.cmd_ready; i++) @(negedge clk);
    @(negedge clk);
    b0.cmd_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag);
    logic [SR-1:0] e;
    for (int i = 0; i < 1000 && rsp_cyc_hist.size() <= rsp_idx; i++) @(negedge clk);
    check({tag, "_rsp_seen"}, 64'(rsp_cyc_hist.size() > rsp_idx), 64'd1);
    if (rsp_cyc_hist.size() <= rsp_idx) return;
    e = exp_q.pop_front();
    check({tag, "_rsp_data"}, 64'(rsp_dat_hist[rsp_idx]), 64'(e));
    check({tag, "_latency"}, 64'(rsp_cyc_hist[rsp_idx] - acc_hist[acc_idx] + 1), 64'(LAT2));
    rsp_idx++;
    acc_idx++;
  endtask

  initial begin
    int s_uir, s_cdr, s_sdr, s_udr, s_rti, s_tdi, a0, r0, n, r1, r2;
    logic p;
    logic [SR-1:0] e;
    b0.cmd_valid = 1'b0; b0.cmd_ir = '0; b0.cmd_data = '0;
    b1.cmd_valid = 1'b0; b1.cmd_ir = '0; b1.cmd_data = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(b0.cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(b0.rsp_valid), 64'd0);
    check("rst_busy", 64'(b0.busy), 64'd0);
    check("rst_tck_tdi", 64'({b0.vji_tck, b0.vji_tdi}), 64'd0);
    check("rst_strobes", 64'({b0.vji_uir, b0.vji_cdr, b0.vji_sdr, b0.vji_udr, b0.vji_rti}), 64'd0);
    check("rst_ir_rsp", 64'({b0.vji_ir_in, b0.rsp_data}), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback with strobe accounting
    s_uir = n_uir; s_cdr = n_cdr; s_sdr = n_sdr; s_udr = n_udr; s_rti = n_rti;
    exp_q.push_back(38'h25_A5A5_C3C3);
    send(2'b01, 38'h25_A5A5_C3C3);
    check("lb_busy", 64'(b0.busy), 64'd1);
    check("lb_ready_low", 64'(b0.cmd_ready), 64'd0);
    expect_rsp("lb");
    check("lb_uir_edges", 64'(n_uir - s_uir), 64'd1);
    check("lb_cdr_edges", 64'(n_cdr - s_cdr), 64'd1);
    check("lb_sdr_edges", 64'(n_sdr - s_sdr), 64'(SR));
    check("lb_udr_edges", 64'(n_udr - s_udr), 64'd1);
    check("lb_rti_edges", 64'(n_rti - s_rti), 64'(RTI_N));
    check("lb_ir_at_uir", 64'(uir_ir), 64'd1);
    @(negedge clk);
    check("lb_ir_held", 64'(b0.vji_ir_in), 64'd1);
    check("lb_idle_after", 64'({b0.cmd_ready, b0.busy}), 64'b10);

    // TDO tied high, zero data out
    loop_mode = 1'b0; tdo_force = 1'b1;
    s_tdi = n_tdi_hi;
    exp_q.push_back(38'h3F_FFFF_FFFF);
    send(2'b10, '0);
    expect_rsp("ones");
    check("ones_tdi_low", 64'(n_tdi_hi - s_tdi), 64'd0);
    check("ones_ir", 64'(b0.vji_ir_in), 64'd2);
    loop_mode = 1'b1;

    // Back-to-back with cmd_valid held, then stray pulses while busy
    a0 = acc_idx; r0 = rsp_idx;
    @(negedge clk);
    b0.cmd_valid = 1'b1; b0.cmd_ir = 2'b11; b0.cmd_data = 38'h12_3456_789A;
    exp_q.push_back(38'h12_3456_789A);
    exp_q.push_back(38'h2A_AAAA_5555);
    for (int i = 0; i < 400 && acc_hist.size() < a0 + 1; i++) @(negedge clk);
    b0.cmd_data = 38'h2A_AAAA_5555;
    for (int i = 0; i < 400 && acc_hist.size() < a0 + 2; i++) @(negedge clk);
    b0.cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat (3) @(negedge clk);
      b0.cmd_valid = 1'b1; b0.cmd_data = 38'h3C_0F0F_F0F0;
      @(negedge clk);
      b0.cmd_valid = 1'b0;
    end
    expect_rsp("b2b_a");
    expect_rsp("b2b_b");
    check("b2b_gap", 64'(acc_hist[a0 + 1]), 64'(rsp_cyc_hist[r0] + 2));
    repeat (200) @(negedge clk);
    check("b2b_rsp_count", 64'(rsp_cyc_hist.size() - r0), 64'd2);
    check("b2b_acc_count", 64'(acc_hist.size() - a0), 64'd2);

    // Reset during SHIFT bit 20
    send(2'b10, 38'h15_5555_AAAA);
    repeat (89) @(negedge clk);
    check("mid_in_shift", 64'(b0.vji_sdr), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready_busy", 64'({b0.cmd_ready, b0.busy, b0.rsp_valid}), 64'b100);
    check("mid_rst_pins", 64'({b0.vji_tck, b0.vji_tdi, b0.vji_uir, b0.vji_cdr, b0.vji_sdr, b0.vji_udr, b0.vji_rti}), 64'd0);
    check("mid_rst_ir_rsp", 64'({b0.vji_ir_in, b0.rsp_data}), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("mid_acc_recorded", 64'(acc_hist.size()), 64'(acc_idx + 1));
    acc_idx++;
    repeat (200) @(negedge clk);
    check("mid_no_rsp", 64'(rsp_cyc_hist.size()), 64'(rsp_idx));
    exp_q.push_back(38'h0A_BCDE_F012);
    send(2'b01, 38'h0A_BCDE_F012);
    expect_rsp("post_rst");

    check("strobe_overlap", 64'(multi_strobe), 64'd0);
    check("tck_stray", 64'(tck_stray), 64'd0);

    // TCK_DIV=1 instance
    exp_q.push_back(38'h00_0000_0001);
    @(negedge clk);
    b1.cmd_valid = 1'b1; b1.cmd_ir = 2'b01; b1.cmd_data = 38'h00_0000_0001;
    for (int i = 0; i < 400 && !b1.cmd_ready; i++) @(negedge clk);
    @(negedge clk);
    b1.cmd_valid = 1'b0;
    n = 1; r1 = -1; r2 = -1; p = b1.vji_tck;
    while (!b1.rsp_valid && n < 400) begin
      @(negedge clk);
      n++;
      if (b1.vji_tck && !p) begin
        if (r1 < 0) r1 = n;
        else if (r2 < 0) r2 = n;
      end
      p = b1.vji_tck;
    end
    check("div1_latency", 64'(n), 64'(LAT1));
    check("div1_tck_period", 64'(r2 - r1), 64'd2);
    e = exp_q.pop_front();
    check("div1_rsp_data", 64'(b1.rsp_data), 64'(e));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no completion by time limit, required finish");
    $fatal(1, "time limit");
  end
endmodule
